// File: rtl/writeback_arbiter_if.sv
// Write-back bundle: ALU and load producer handshakes plus the
// register-file write port and FIFO occupancy.
//   master: producers / register file side (drives valid/reg/data)
//   slave : writeback_arbiter (drives ready, write port, pending)
interface writeback_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
);
    logic                          alu_valid;
    logic                          alu_ready;
    logic [ADDR_W-1:0]             alu_reg;
    logic [DATA_W-1:0]             alu_data;
    logic                          mem_valid;
    logic                          mem_ready;
    logic [ADDR_W-1:0]             mem_reg;
    logic [DATA_W-1:0]             mem_data;
    logic                          regWrite;
    logic [ADDR_W-1:0]             writeReg;
    logic [DATA_W-1:0]             writeData;
    logic [$clog2(FIFO_DEPTH):0]   pending;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready,
        input  regWrite, writeReg, writeData, pending
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready,
        output regWrite, writeReg, writeData, pending
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: owns the register-file write port, load results
// win, ALU results queue in a FIFO with a bounded-starvation override.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : writeback_arbiter_if.slave (handshakes, write port, pending)
module writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

    logic [ADDR_W-1:0] r_fifo_reg [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_dat [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [STV_W-1:0]  r_starve;
    logic              r_we;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;

    logic              w_alu_ready;
    logic              w_mem_ready;
    logic              w_mem_fire;
    logic              w_alu_fire;
    logic              w_enq;
    logic              w_has;
    logic              w_deq;
    logic [STV_W-1:0]  w_starve_nxt;

    assign w_alu_ready = r_count < DEPTH_C;
    assign w_mem_ready = r_starve != STARVE_C;
    assign w_mem_fire  = bus.mem_valid & w_mem_ready;
    assign w_alu_fire  = bus.alu_valid & w_alu_ready;
    // Writes to x0 complete the handshake but are never stored.
    assign w_enq       = w_alu_fire & (bus.alu_reg != '0);
    assign w_has       = r_count != '0;
    // A load beat (even one to x0) takes the slot; the head waits.
    assign w_deq       = ~w_mem_fire & w_has;

    // Count only losses suffered while something is queued; any
    // dequeue or an empty FIFO resets the count.
    always_comb begin
        w_starve_nxt = '0;
        if (w_mem_fire && w_has) begin
            if (r_starve == STARVE_C)
                w_starve_nxt = r_starve;
            else
                w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_reg[r_wr_ptr] <= bus.alu_reg;
            r_fifo_dat[r_wr_ptr] <= bus.alu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_enq)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            r_starve <= w_starve_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else if (w_mem_fire) begin
            r_we <= bus.mem_reg != '0;
            if (bus.mem_reg != '0) begin
                r_wreg  <= bus.mem_reg;
                r_wdata <= bus.mem_data;
            end
        end else if (w_deq) begin
            r_we    <= 1'b1;
            r_wreg  <= r_fifo_reg[r_rd_ptr];
            r_wdata <= r_fifo_dat[r_rd_ptr];
        end else begin
            r_we <= 1'b0;
        end
    end

    assign bus.alu_ready = w_alu_ready;
    assign bus.mem_ready = w_mem_ready;
    assign bus.regWrite  = r_we;
    assign bus.writeReg  = r_wreg;
    assign bus.writeData = r_wdata;
    assign bus.pending   = r_count;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus
// random traffic compared against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;
    localparam int SMAX = 3;

    logic clk;
    logic rst;

    writeback_arbiter_if #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
    ) bus ();

    writeback_arbiter #(
        .DATA_W(DW), .ADDR_W(AW),
        .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    logic [AW-1:0] q_reg [$];
    logic [DW-1:0] q_dat [$];
    int            starve;
    logic [AW-1:0] last_reg;
    logic [DW-1:0] last_dat;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_reg.delete();
        q_dat.delete();
        starve   = 0;
        last_reg = '0;
        last_dat = '0;
    endtask

    // One clock of traffic: drive, check readies before the edge,
    // advance the model, check the write port after the edge.
    task automatic step(input bit av, input logic [AW-1:0] ar,
                        input logic [DW-1:0] ad, input bit mv,
                        input logic [AW-1:0] mr,
                        input logic [DW-1:0] md);
        bit m_ar;
        bit m_mr;
        bit exp_we;
        int sz;
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_reg   = mr;
        bus.mem_data  = md;
        @(negedge clk);
        sz   = q_reg.size();
        m_ar = sz < DEPTH;
        m_mr = starve != SMAX;
        check("alu_ready", 64'(bus.alu_ready), 64'(m_ar));
        check("mem_ready", 64'(bus.mem_ready), 64'(m_mr));
        check("pending", 64'(bus.pending), 64'(sz));
        exp_we = 1'b0;
        if (mv && m_mr) begin
            if (mr != 0) begin
                exp_we   = 1'b1;
                last_reg = mr;
                last_dat = md;
            end
            starve = (sz > 0) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        end else if (sz > 0) begin
            exp_we   = 1'b1;
            last_reg = q_reg.pop_front();
            last_dat = q_dat.pop_front();
            starve   = 0;
        end else begin
            starve = 0;
        end
        if (av && m_ar && ar != 0) begin
            q_reg.push_back(ar);
            q_dat.push_back(ad);
        end
        @(posedge clk);
        #1;
        check("regWrite", 64'(bus.regWrite), 64'(exp_we));
        check("writeReg", 64'(bus.writeReg), 64'(last_reg));
        check("writeData", 64'(bus.writeData), 64'(last_dat));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        rst = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_reg   = '0;
        bus.mem_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_regWrite", 64'(bus.regWrite), 64'd0);
        check("rst_writeReg", 64'(bus.writeReg), 64'd0);
        check("rst_writeData", 64'(bus.writeData), 64'd0);
        check("rst_pending", 64'(bus.pending), 64'd0);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
        rst = 1'b0;
        idle(2);

        // Single ALU write, appears one cycle after enqueue.
        step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
        idle(2);

        // Simultaneous load and ALU result.
        step(1'b1, 5'd3, 32'h5555, 1'b1, 5'd7, 32'hAAAA);
        idle(2);

        // Back-to-back ALU writes, no loads.
        for (int i = 1; i <= 6; i++)
            step(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, '0, '0);
        idle(2);

        // Fill the FIFO under continuous loads, then drain.
        for (int i = 1; i <= 6; i++)
            step(1'b1, 5'(i + 8), 32'h200 + 32'(i),
                 1'b1, 5'(i + 16), 32'h300 + 32'(i));
        idle(6);

        // One queued entry against a continuous load stream.
        step(1'b1, 5'd9, 32'h9999, 1'b1, 5'd10, 32'hA000);
        for (int i = 1; i <= 6; i++)
            step(1'b0, '0, '0, 1'b1, 5'd11, 32'hB000 + 32'(i));
        idle(2);

        // Register 0 on both paths.
        step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        idle(2);

        // Reset with three entries queued.
        step(1'b1, 5'd12, 32'hC001, 1'b1, 5'd20, 32'hD001);
        step(1'b1, 5'd13, 32'hC002, 1'b1, 5'd21, 32'hD002);
        step(1'b1, 5'd14, 32'hC003, 1'b1, 5'd22, 32'hD003);
        check("pre_rst_pending", 64'(bus.pending), 64'd3);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_pending", 64'(bus.pending), 64'd0);
        check("midrst_regWrite", 64'(bus.regWrite), 64'd0);
        check("midrst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("midrst_mem_ready", 64'(bus.mem_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60,
                 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 99) < 55,
                 5'($urandom_range(0, 31)), $urandom);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
